// File: rtl/xlr8_text_renderer.sv
// xlr8_text_renderer
// Text-mode pixel generator for a 640x480 raster: 80x30 cells of 8x16 pixels.
// It fetches the character and attribute bytes for each cell from the shared
// char/attr RAM, looks up the glyph row in an external font ROM, and maps the
// resulting pixel through a 16-entry CGA palette. Sync and DE are delayed so
// that they leave the block in step with rgb, exactly 5 cycles after input.
//
// Ports:
//   clk_pixel, rstn             pixel clock, asynchronous active-low reset
//   cx, cy, de_in, hsync_in,    raster position and timing from the video
//   vsync_in                    timing counters (all mutually aligned)
//   ram_address, ram_char_re,   shared port-B address and read enables of
//   ram_attr_re                 the char and attribute RAMs
//   ram_char_data,              RAM read data, 1-cycle registered latency
//   ram_attr_data
//   font_addr, font_data        font ROM {char, scanline} address and glyph
//                               row (bit7 = leftmost pixel), 1-cycle latency
//   cursor_en, cursor_col,      underline cursor position (quasi-static)
//   cursor_row
//   rgb, de_out, hsync_out,     pixel colour and matching delayed timing
//   vsync_out
//   blink_phase                 current blink half-period
module xlr8_text_renderer #(
  parameter int BLINK_FRAMES      = 32,
  parameter int COLS              = 80,
  parameter int CURSOR_FIRST_LINE = 14
) (
  input  logic        clk_pixel,
  input  logic        rstn,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [12:0] ram_address,
  output logic        ram_char_re,
  output logic        ram_attr_re,
  input  logic [7:0]  ram_char_data,
  input  logic [7:0]  ram_attr_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [23:0] rgb,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blink_phase
);

  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);
  localparam logic [3:0] CURSOR_LINE = 4'(CURSOR_FIRST_LINE);

  // cy[9] is never needed: active video stays below line 480.
  logic unused_bits;
  assign unused_bits = cy[9];

  // Cell coordinates and RAM address of the incoming pixel
  logic [4:0]  cell_row;
  logic [6:0]  cell_col;
  logic [12:0] addr_next;

  assign cell_row = cy[8:4];
  assign cell_col = cx[9:3];

  generate
    if (COLS == 80) begin : g_addr_shift
      // row*80 as row*64 + row*16 keeps the address path to two adders.
      assign addr_next = {2'b00, cell_row, 6'd0} + {4'd0, cell_row, 4'd0}
                       + {6'd0, cell_col};
    end else begin : g_addr_mul
      assign addr_next = {8'd0, cell_row} * 13'(COLS) + {6'd0, cell_col};
    end
  endgenerate

  // Pipeline state; index = cycle after the input sample at which it is valid
  logic [12:0] ram_address_reg;
  logic        ram_re_reg;
  logic [5:0]  sb_reg [1:4];     // {de, hs, vs, pixel-in-cell x}
  logic [3:0]  sl_reg [1:2];     // scanline within cell
  logic [4:0]  row_reg;
  logic [6:0]  col_reg;
  logic        hit_reg [2:4];    // cursor position match (before blink gating)
  logic [11:0] font_addr_reg;
  logic [7:0]  attr_reg [3:4];

  logic        cursor_hit_next;
  assign cursor_hit_next = cursor_en && (row_reg == cursor_row) &&
                           (col_reg == cursor_col) && (sl_reg[1] >= CURSOR_LINE);

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      ram_address_reg <= '0;
      ram_re_reg      <= 1'b0;
      for (int i = 1; i <= 4; i++) sb_reg[i] <= '0;
      sl_reg[1]       <= '0;
      sl_reg[2]       <= '0;
      row_reg         <= '0;
      col_reg         <= '0;
      for (int i = 2; i <= 4; i++) hit_reg[i] <= 1'b0;
      font_addr_reg   <= '0;
      attr_reg[3]     <= '0;
      attr_reg[4]     <= '0;
    end else begin
      ram_re_reg <= de_in;
      // Address holds during blanking so the RAM port stays quiet.
      if (de_in) ram_address_reg <= addr_next;
      sb_reg[1] <= {de_in, hsync_in, vsync_in, cx[2:0]};
      for (int i = 2; i <= 4; i++) sb_reg[i] <= sb_reg[i-1];
      sl_reg[1]   <= cy[3:0];
      sl_reg[2]   <= sl_reg[1];
      row_reg     <= cell_row;
      col_reg     <= cell_col;
      hit_reg[2]  <= cursor_hit_next;
      hit_reg[3]  <= hit_reg[2];
      hit_reg[4]  <= hit_reg[3];
      font_addr_reg <= {ram_char_data, sl_reg[2]};
      attr_reg[3] <= ram_attr_data;
      attr_reg[4] <= attr_reg[3];
    end
  end

  // CGA palette; index 6 is dimmed on green to give brown instead of olive.
  function automatic logic [23:0] cga_colour(input logic [3:0] idx);
    logic [7:0] r, g, b;
    r = (idx[2] ? 8'hAA : 8'h00) + (idx[3] ? 8'h55 : 8'h00);
    g = (idx[1] ? 8'hAA : 8'h00) + (idx[3] ? 8'h55 : 8'h00);
    b = (idx[0] ? 8'hAA : 8'h00) + (idx[3] ? 8'h55 : 8'h00);
    if (idx == 4'd6) g = 8'h55;
    return {r, g, b};
  endfunction

  // Blink timer state
  logic       vs_prev_reg;
  logic [7:0] frame_cnt_reg;
  logic       blink_phase_reg;

  // Pixel colour selection at stage 4 (font_data valid)
  logic        glyph_bit;
  logic [3:0]  colour_idx;
  logic [23:0] rgb_next;

  always_comb begin
    glyph_bit  = font_data[3'd7 - sb_reg[4][2:0]];
    colour_idx = glyph_bit ? attr_reg[4][3:0] : {1'b0, attr_reg[4][6:4]};
    if (attr_reg[4][7] && blink_phase_reg) colour_idx = {1'b0, attr_reg[4][6:4]};
    // Cursor is applied last so it wins over attribute blink.
    if (hit_reg[4] && !blink_phase_reg) colour_idx = attr_reg[4][3:0];
    rgb_next = sb_reg[4][5] ? cga_colour(colour_idx) : 24'h000000;
  end

  logic [23:0] rgb_reg;
  logic        de_out_reg, hs_out_reg, vs_out_reg;

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      rgb_reg    <= '0;
      de_out_reg <= 1'b0;
      hs_out_reg <= 1'b0;
      vs_out_reg <= 1'b0;
    end else begin
      rgb_reg    <= rgb_next;
      de_out_reg <= sb_reg[4][5];
      hs_out_reg <= sb_reg[4][4];
      vs_out_reg <= sb_reg[4][3];
    end
  end

  // Frame counter advances once per vsync rising edge, however long it is held.
  logic vsync_rise;
  assign vsync_rise = vsync_in && !vs_prev_reg;

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      vs_prev_reg     <= 1'b0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      vs_prev_reg <= vsync_in;
      if (vsync_rise) begin
        if (frame_cnt_reg == BLINK_LAST) begin
          frame_cnt_reg   <= '0;
          blink_phase_reg <= !blink_phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
      end
    end
  end

  assign ram_address = ram_address_reg;
  assign ram_char_re = ram_re_reg;
  assign ram_attr_re = ram_re_reg;
  assign font_addr   = font_addr_reg;
  assign rgb         = rgb_reg;
  assign de_out      = de_out_reg;
  assign hsync_out   = hs_out_reg;
  assign vsync_out   = vs_out_reg;
  assign blink_phase = blink_phase_reg;

endmodule

// File: tb/tb_xlr8_text_renderer.sv
// tb_xlr8_text_renderer
// Directed bench for xlr8_text_renderer with BLINK_FRAMES=2. The bench owns
// models of the char/attr RAMs and the font ROM; every driven cycle pushes the
// expected {de, hs, vs, rgb} onto a queue, popped and compared 5 cycles later.
module tb_xlr8_text_renderer;

  logic        clk_pixel = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  cx = '0, cy = '0;
  logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [12:0] ram_address;
  logic        ram_char_re, ram_attr_re;
  logic [7:0]  ram_char_data = '0, ram_attr_data = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic        cursor_en = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic [23:0] rgb;
  logic        de_out, hsync_out, vsync_out, blink_phase;

  always #5 clk_pixel = ~clk_pixel;

  xlr8_text_renderer #(.BLINK_FRAMES(2), .COLS(80), .CURSOR_FIRST_LINE(14)) dut (
    .clk_pixel(clk_pixel), .rstn(rstn), .cx(cx), .cy(cy), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .ram_address(ram_address),
    .ram_char_re(ram_char_re), .ram_attr_re(ram_attr_re),
    .ram_char_data(ram_char_data), .ram_attr_data(ram_attr_data),
    .font_addr(font_addr), .font_data(font_data), .cursor_en(cursor_en),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .rgb(rgb),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .blink_phase(blink_phase)
  );

  // External memories seen by the DUT
  logic [7:0] char_mem [8192];
  logic [7:0] attr_mem [8192];
  logic [7:0] font_mem [4096];

  always @(posedge clk_pixel) begin
    if (ram_char_re) ram_char_data <= char_mem[ram_address];
    if (ram_attr_re) ram_attr_data <= attr_mem[ram_address];
    font_data <= font_mem[font_addr];
  end

  localparam logic [23:0] PAL [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  int tests = 0;
  int fails = 0;
  logic [26:0] exp_q [$];

  // Reference state
  logic        m_phase = 1'b0;
  int          m_cnt = 0;
  logic        m_prev_vs = 1'b0;
  logic        m_prev_de = 1'b0;
  logic [12:0] m_last_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] model_rgb(input logic [9:0] x, input logic [9:0] y);
    int row, col, a;
    logic [7:0] ch, at, gl;
    logic [3:0] idx;
    row = int'(y[8:4]);
    col = int'(x[9:3]);
    a   = row * 80 + col;
    ch  = char_mem[a];
    at  = attr_mem[a];
    gl  = font_mem[{ch, y[3:0]}];
    idx = gl[7 - int'(x[2:0])] ? at[3:0] : {1'b0, at[6:4]};
    if (at[7] && m_phase) idx = {1'b0, at[6:4]};
    if (cursor_en && row == int'(cursor_row) && col == int'(cursor_col) &&
        y[3:0] >= 4'd14 && !m_phase) idx = at[3:0];
    return PAL[idx];
  endfunction

  // One pixel clock: check what is due now, then drive the next input.
  task automatic step(input logic [9:0] x, input logic [9:0] y,
                      input logic de, input logic hs, input logic vs);
    logic [26:0] e;
    logic [23:0] er;
    @(negedge clk_pixel);
    e = exp_q.pop_front();
    check("out", {5'd0, de_out, hsync_out, vsync_out, rgb}, {5'd0, e});
    if (e[26]) $display("[TB] pixel rgb=%06h expected=%06h", rgb, e[23:0]);
    check("blink", {31'd0, blink_phase}, {31'd0, m_phase});
    check("read_en", {30'd0, ram_char_re, ram_attr_re}, {30'd0, m_prev_de, m_prev_de});
    check("addr", {19'd0, ram_address}, {19'd0, m_last_addr});
    cx = x; cy = y; de_in = de; hsync_in = hs; vsync_in = vs;
    if (vs && !m_prev_vs) begin
      if (m_cnt == 1) begin
        m_cnt = 0;
        m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
    m_prev_vs = vs;
    m_prev_de = de;
    if (de) m_last_addr = 13'(int'(y[8:4]) * 80 + int'(x[9:3]));
    er = de ? model_rgb(x, y) : 24'h000000;
    exp_q.push_back({de, hs, vs, er});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drive one active pixel and read its colour exactly 5 cycles later.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] expv);
    step(x, y, 1'b1, 1'b0, 1'b0);
    idle(4);
    check({tag, "_before"}, {31'd0, de_out}, 32'd0);
    @(posedge clk_pixel);
    #1;
    check(tag, {8'd0, rgb}, {8'd0, expv});
  endtask

  task automatic vs_pulse(input int n);
    idle(6);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    idle(6);
  endtask

  task automatic draw_span(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) step(10'(x), 10'(y), 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      char_mem[i] = 8'($urandom);
      attr_mem[i] = 8'($urandom) & 8'h7F;
    end
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    // Glyph/palette cells 0 and 1, blink cell (row 3, col 0), cursor cell (row 2, col 3)
    char_mem[0] = 8'h41; attr_mem[0] = 8'h1E;
    char_mem[1] = 8'h41; attr_mem[1] = 8'h06;
    char_mem[240] = 8'h42; attr_mem[240] = 8'h9F;
    char_mem[163] = 8'h43; attr_mem[163] = 8'h07;
    for (int s = 0; s < 16; s++) begin
      font_mem[{8'h41, 4'(s)}] = 8'h80;
      font_mem[{8'h42, 4'(s)}] = 8'hFF;
      font_mem[{8'h43, 4'(s)}] = 8'h00;
    end

    // Reset with random activity on every input
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_pixel);
      cx = 10'($urandom); cy = 10'($urandom);
      de_in = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      cursor_en = 1'($urandom); cursor_col = 7'($urandom); cursor_row = 5'($urandom);
      check("reset_rgb", {8'd0, rgb}, 32'd0);
    end
    @(negedge clk_pixel);
    check("reset_sync", {29'd0, de_out, hsync_out, vsync_out}, 32'd0);
    check("reset_blink", {31'd0, blink_phase}, 32'd0);
    check("reset_ram", {16'd0, ram_address, ram_char_re, ram_attr_re, 1'b0}, 32'd0);
    check("reset_font", {20'd0, font_addr}, 32'd0);
    cx = '0; cy = '0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back('0);

    idle(3);
    // First active pixel after reset: de_out rises exactly 5 cycles later
    step(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("first_de_early", {31'd0, de_out}, 32'd0);
    @(posedge clk_pixel);
    #1;
    check("first_de", {31'd0, de_out}, 32'd1);
    idle(5);

    // Addressing: last cell of the screen, then row 1 col 1
    step(10'd639, 10'd479, 1'b1, 1'b0, 1'b0);
    @(posedge clk_pixel);
    #1;
    check("addr_last", {19'd0, ram_address}, 32'd2399);
    check("re_last", {30'd0, ram_char_re, ram_attr_re}, 32'd3);
    step(10'd8, 10'd16, 1'b1, 1'b0, 1'b0);
    @(posedge clk_pixel);
    #1;
    check("addr_81", {19'd0, ram_address}, 32'd81);
    idle(6);

    // Glyph and palette
    probe("glyph_fg", 10'd0, 10'd0, 24'hFFFF55);
    probe("glyph_bg", 10'd1, 10'd0, 24'h0000AA);
    probe("brown", 10'd8, 10'd0, 24'hAA5500);
    draw_span(3, 0, 15);
    idle(6);

    // Blink: two vsync edges toggle the phase, a long vsync counts once
    draw_span(48, 0, 7);
    vs_pulse(3);
    check("blink_one_edge", {31'd0, blink_phase}, 32'd0);
    probe("blink_off", 10'd2, 10'd48, 24'hFFFFFF);
    vs_pulse(100);
    check("blink_two_edges", {31'd0, blink_phase}, 32'd1);
    probe("blink_on", 10'd2, 10'd48, 24'h0000AA);
    draw_span(49, 0, 7);
    idle(6);

    // Cursor: hidden while blink_phase=1, underline on lines 14..15 otherwise
    cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
    idle(2);
    probe("cursor_hidden", 10'd24, 10'd46, 24'h000000);
    vs_pulse(2);
    vs_pulse(2);
    check("blink_back", {31'd0, blink_phase}, 32'd0);
    draw_span(46, 24, 31);
    draw_span(47, 20, 35);
    draw_span(45, 24, 31);
    idle(6);
    probe("cursor_on", 10'd27, 10'd47, 24'hAAAAAA);
    probe("cursor_above", 10'd27, 10'd45, 24'h000000);

    // Random active pixels anywhere on screen
    for (int i = 0; i < 64; i++)
      step(10'($urandom_range(639)), 10'($urandom_range(479)), 1'b1, 1'b0, 1'b0);
    idle(6);

    // Blanking with an hsync pulse; RAM/font data keep changing underneath
    for (int i = 0; i < 16; i++)
      step(10'($urandom), 10'($urandom), 1'b0, (i >= 4 && i < 8), 1'b0);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xlr8_text_renderer.md
Name: xlr8_text_renderer

Overview:
- Text-mode pixel generator for the 640x480 HDMI path: 80x30 cells of 8x16 pixels.
- Consumes the char and attribute dual-port RAM read ports.
- Looks up glyph rows in an external font ROM and drives 24-bit RGB into the TMDS encoder.
- Sits between the video timing counters and the encoder. It delays DE/HSYNC/VSYNC so they stay aligned with the RGB output.

Parameters:
- BLINK_FRAMES, 32, number of frames per blink half-period (valid range 2..255).
- COLS, 80, character columns per row (sets the row stride of the RAM address).
- CURSOR_FIRST_LINE, 14, first cell scanline of the underline cursor (cursor covers CURSOR_FIRST_LINE..15).

Ports:
- clk_pixel  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- cx  in  10  horizontal pixel counter
- cy  in  10  vertical line counter
- de_in  in  1  active-video flag, aligned with cx/cy
- hsync_in  in  1  horizontal sync, aligned with cx/cy
- vsync_in  in  1  vertical sync, aligned with cx/cy
- ram_address  out  13  shared char/attr RAM port-B address
- ram_char_re  out  1  char RAM read enable
- ram_attr_re  out  1  attr RAM read enable
- ram_char_data  in  8  char RAM q, 1-cycle registered latency
- ram_attr_data  in  8  attr RAM q, 1-cycle registered latency
- font_addr  out  12  {char[7:0], scanline[3:0]}
- font_data  in  8  glyph row, 1-cycle latency, bit7 = leftmost pixel
- cursor_en  in  1  cursor enable (quasi-static)
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- rgb  out  24  {R,G,B}, 8 bits each
- de_out  out  1  DE delayed to match rgb
- hsync_out  out  1  HSYNC delayed to match rgb
- vsync_out  out  1  VSYNC delayed to match rgb
- blink_phase  out  1  current blink state

Behaviour:
- Single clock domain clk_pixel. On rstn low, asynchronously clear all pipeline registers, the frame counter and blink_phase. All outputs read 0 during reset, including rgb, syncs, ram_address, the read enables and font_addr.
- Reset mid-frame: the pipeline restarts clean. The first valid output is 5 cycles after the first sampled de_in=1.
- Pipeline, with input sampled at cycle T:
  - T+1: ram_address = cy[8:4]*COLS + cx[9:3], computed as (row<<6)+(row<<4)+col, 13-bit. ram_char_re = ram_attr_re = de_in. Register cx[2:0], cy[3:0], row, col, de, hs, vs.
  - T+2: char/attr valid. Register font_addr = {char, cy[3:0]} and attr.
  - T+3: font_data is requested.
  - T+4: font_data valid. Pixel = font_data[7 - cx[2:0]].
  - T+5: rgb, de_out, hsync_out and vsync_out are registered. Total latency is exactly 5 cycles, for every signal.
- When de_in is low: read enables are low, ram_address holds its last value, and rgb = 0 at T+5. Addresses ≥ 2400 are never issued, because de_in never covers cy ≥ 480.
- Attribute byte:
  - fg = attr[3:0]; bg = attr[6:4] (index 0..7); blink = attr[7].
  - If blink=1 and blink_phase=1, the pixel uses bg regardless of glyph.
- Cursor:
  - Condition: cursor_en=1, row==cursor_row, col==cursor_col, scanline ≥ CURSOR_FIRST_LINE, and blink_phase=0.
  - Effect: the pixel is forced to fg. Cursor overrides attribute blink.
- Palette (16-entry CGA), for index i:
  - R = (i[2]?0xAA:0) + (i[3]?0x55:0); G likewise from i[1]; B likewise from i[0].
  - Exception, i=6: G = 0x55, giving brown (0xAA,0x55,0x00).
- Blink timer:
  - An 8-bit frame counter increments on each rising edge of vsync_in, detected with a registered previous value. A vsync_in held high counts once.
  - When the counter reaches BLINK_FRAMES-1, it wraps to 0 on the next edge and blink_phase toggles.
  - blink_phase changes only at a vsync edge, never mid-frame.
- Simultaneous events: a vsync edge while de_in=1 is still counted; rendering is unaffected.

Test Plan:
- Reset: hold rstn=0 with random inputs -> rgb=0, de_out=hsync_out=vsync_out=0, blink_phase=0. Release rstn, drive de_in=1 at cx=0,cy=0 -> de_out=1 exactly 5 cycles later.
- Addressing: cx=639, cy=479, de_in=1 -> next cycle ram_address=2399 and both read enables =1. cx=8, cy=16 -> ram_address=81.
- Glyph and palette: char=0x41, attr=0x1E, font_data=0x80, cx[2:0]=0 -> rgb=0xFFFF55. cx[2:0]=1 -> rgb=0x0000AA. attr fg=6, lit pixel -> rgb=0xAA5500.
- Blink: BLINK_FRAMES=2, attr=0x9F, glyph all ones. Frames 0-1 -> 0xFFFFFF. After 2 vsync rising edges -> blink_phase=1, rgb=0x0000AA. vsync held high 100 cycles -> counted once.
- Cursor: cursor_en=1, col=3, row=2, blink_phase=0, attr=0x07, glyph=0x00. Pixels at cx=24..31, cy=46..47 -> 0xAAAAAA. cy=45 -> 0x000000. blink_phase=1 -> cursor absent.
- Blanking: de_in=0 with any RAM/font data -> rgb=0, read enables low. hsync_in pulse -> hsync_out identical pulse delayed 5 cycles.
